// File: rtl/adpll_cfg_pkg.sv
// Shared widths, select codes, reset defaults, range limits and FSM encoding
// for the ADPLL configuration register bank.
package adpll_cfg_pkg;

    localparam int DW   = 5;
    localparam int NREG = 6;
    localparam int SELW = 3;

    localparam logic [SELW-1:0] SEL_KP       = 3'd0;
    localparam logic [SELW-1:0] SEL_KI       = 3'd1;
    localparam logic [SELW-1:0] SEL_DCO_INIT = 3'd2;
    localparam logic [SELW-1:0] SEL_DIV_N    = 3'd3;
    localparam logic [SELW-1:0] SEL_TDC_OFS  = 3'd4;
    localparam logic [SELW-1:0] SEL_LOCK_THR = 3'd5;

    localparam logic [DW-1:0] KP_DEF       = 5'd4;
    localparam logic [DW-1:0] KI_DEF       = 5'd1;
    localparam logic [DW-1:0] DCO_INIT_DEF = 5'd16;
    localparam logic [DW-1:0] DIV_N_DEF    = 5'd8;
    localparam logic [DW-1:0] TDC_OFS_DEF  = 5'd0;
    localparam logic [DW-1:0] LOCK_THR_DEF = 5'd2;

    localparam logic [DW-1:0] DIV_N_MIN = 5'd2;
    localparam logic [DW-1:0] KP_MIN    = 5'd1;

    // Register file packed so that index == param_sel code.
    typedef logic [NREG-1:0][DW-1:0] regs_t;

    localparam regs_t REGS_DEF = {LOCK_THR_DEF, TDC_OFS_DEF, DIV_N_DEF,
                                  DCO_INIT_DEF, KI_DEF, KP_DEF};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic write_ok(input logic [SELW-1:0] sel,
                                      input logic [DW-1:0]   val);
        logic ok;
        ok = 1'b1;
        if (sel >= 3'(NREG))                     ok = 1'b0;
        else if (sel == SEL_DIV_N && val < DIV_N_MIN) ok = 1'b0;
        else if (sel == SEL_KP && val < KP_MIN)       ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/adpll_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset; reusable for any
// single-bit asynchronous level (pgm, clr, clk_ref).
module adpll_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // NOTE: non-blocking assignments so both stages sample pre-edge values and
    // the chain really is two flops deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/adpll_cfg_regs.sv
// ADPLL loop-parameter register bank: synchronizes pin-level pgm/clr, writes one
// of six range-checked registers per pgm rise. Readback mux: ADPLL_CFG_READBACK_EN.
module adpll_cfg_regs
    import adpll_cfg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pgm_in,
    input  logic            clr_in,
    input  logic [SELW-1:0] param_sel,
    input  logic [DW-1:0]   pgm_value,
    output logic [DW-1:0]   kp,
    output logic [DW-1:0]   ki,
    output logic [DW-1:0]   dco_init,
    output logic [DW-1:0]   div_n,
    output logic [DW-1:0]   tdc_ofs,
    output logic [DW-1:0]   lock_thr,
    output logic            dco_load,
    output logic            wr_ack,
    output logic            wr_err,
    output logic [DW-1:0]   rd_data
);

    logic   pgm_s2, clr_s2, pgm_rise, wr_ok;
    logic   pgm_s3_q, pgm_s3_d;
    logic   clr_s3_q, clr_s3_d;
    state_e state_q, state_d;
    regs_t  regs_q, regs_d;
    logic   wr_ack_q, wr_ack_d;
    logic   wr_err_q, wr_err_d;
    logic   dco_load_q, dco_load_d;

    adpll_sync2 u_sync_pgm (.clk(clk), .rst(rst), .d(pgm_in), .q(pgm_s2));
    adpll_sync2 u_sync_clr (.clk(clk), .rst(rst), .d(clr_in), .q(clr_s2));

    assign pgm_rise = pgm_s2 & ~pgm_s3_q;
    assign wr_ok    = write_ok(param_sel, pgm_value);

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pgm_s3_d   = pgm_s2;
        clr_s3_d   = clr_s2;
        state_d    = state_q;
        regs_d     = regs_q;
        wr_ack_d   = 1'b0;
        wr_err_d   = 1'b0;
        dco_load_d = clr_s3_q & ~clr_s2;

        if (clr_s2) begin
            state_d = HOLD;
            regs_d  = REGS_DEF;
        end else begin
            unique case (state_q)
                // The write commits on the IDLE->WRITE edge, so the WRITE
                // cycle is the one in which the ack/err pulse is visible.
                IDLE: begin
                    if (pgm_rise) begin
                        state_d = WRITE;
                        if (wr_ok) begin
                            for (int i = 0; i < NREG; i++) begin
                                if (param_sel == 3'(i)) regs_d[i] = pgm_value;
                            end
                            wr_ack_d   = 1'b1;
                            dco_load_d = (param_sel == SEL_DCO_INIT);
                        end else begin
                            wr_err_d = 1'b1;
                        end
                    end
                end
                WRITE:   state_d = HOLD;
                HOLD:    if (!pgm_s2) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pgm_s3_q   <= 1'b0;
            clr_s3_q   <= 1'b0;
            state_q    <= IDLE;
            regs_q     <= REGS_DEF;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            dco_load_q <= 1'b0;
        end else begin
            pgm_s3_q   <= pgm_s3_d;
            clr_s3_q   <= clr_s3_d;
            state_q    <= state_d;
            regs_q     <= regs_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            dco_load_q <= dco_load_d;
        end
    end

    assign kp       = regs_q[SEL_KP];
    assign ki       = regs_q[SEL_KI];
    assign dco_init = regs_q[SEL_DCO_INIT];
    assign div_n    = regs_q[SEL_DIV_N];
    assign tdc_ofs  = regs_q[SEL_TDC_OFS];
    assign lock_thr = regs_q[SEL_LOCK_THR];
    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign dco_load = dco_load_q;

`ifdef ADPLL_CFG_READBACK_EN
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (param_sel == 3'(i)) rd_data_d = regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`else
    assign rd_data = '0;
`endif

endmodule

// File: tb/tb_adpll_cfg_regs.sv
// Self-checking bench for adpll_cfg_regs: table-driven writes with an ack/err
// scoreboard, plus clear, readback and asynchronous-reset sequences.
module tb_adpll_cfg_regs;
    import adpll_cfg_pkg::*;

    logic            clk = 1'b0;
    logic            rst, pgm_in, clr_in;
    logic [SELW-1:0] param_sel;
    logic [DW-1:0]   pgm_value;
    logic [DW-1:0]   kp, ki, dco_init, div_n, tdc_ofs, lock_thr, rd_data;
    logic            dco_load, wr_ack, wr_err;

    adpll_cfg_regs dut (
        .clk(clk), .rst(rst), .pgm_in(pgm_in), .clr_in(clr_in),
        .param_sel(param_sel), .pgm_value(pgm_value),
        .kp(kp), .ki(ki), .dco_init(dco_init), .div_n(div_n),
        .tdc_ofs(tdc_ofs), .lock_thr(lock_thr), .dco_load(dco_load),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_data(rd_data)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [4:0] val;
        bit         ack;
        logic [4:0] tgt;
    } vec_t;

    typedef struct {
        bit ack;
        bit dco;
    } sb_t;

    sb_t        sb[$];
    sb_t        mon_e;
    vec_t       vecs[12];
    logic [4:0] exp_r[6];
    int         total = 0;
    int         bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] dut_reg(input int i);
        case (i)
            0:       return kp;
            1:       return ki;
            2:       return dco_init;
            3:       return div_n;
            4:       return tdc_ofs;
            5:       return lock_thr;
            default: return 5'd0;
        endcase
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_reg%0d", tag, i), dut_reg(i), exp_r[i]);
        end
    endtask

    task automatic set_defaults();
        exp_r[0] = 5'd4;  exp_r[1] = 5'd1; exp_r[2] = 5'd16;
        exp_r[3] = 5'd8;  exp_r[4] = 5'd0; exp_r[5] = 5'd2;
    endtask

    // Every ack/err pulse must have been announced on the scoreboard.
    always @(posedge clk) begin
        #1;
        if (wr_ack === 1'b1 || wr_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, wr_ack, wr_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_wr_ack", wr_ack, mon_e.ack);
                check("sb_wr_err", wr_err, !mon_e.ack);
                check("sb_dco_load", dco_load, mon_e.dco);
            end
        end
    end

    task automatic do_write(input vec_t v, input string tag);
        sb_t e;
        int  seen_at;
        @(negedge clk);
        param_sel = v.sel;
        pgm_value = v.val;
        @(negedge clk);
        e.ack = v.ack;
        e.dco = v.ack && (v.sel == 3'd2);
        sb.push_back(e);
        pgm_in  = 1'b1;
        seen_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (seen_at == 0 && (wr_ack === 1'b1 || wr_err === 1'b1)) begin
                seen_at = i;
                if (v.sel < 3'd6) check({tag, "_target"}, dut_reg(int'(v.sel)), v.tgt);
            end
            @(negedge clk);
            if (i == 5) pgm_in = 1'b0;
        end
        if (seen_at == 0) begin
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_back());
        end else begin
            check({tag, "_latency"}, seen_at, 32'd3);
        end
        if (v.sel < 3'd6) exp_r[v.sel] = v.tgt;
        check_all_regs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dseen;
        vec_t v;

        vecs[0]  = '{3'd1, 5'd7,  1'b1, 5'd7};
        vecs[1]  = '{3'd2, 5'd23, 1'b1, 5'd23};
        vecs[2]  = '{3'd3, 5'd1,  1'b0, 5'd8};
        vecs[3]  = '{3'd6, 5'd5,  1'b0, 5'd0};
        vecs[4]  = '{3'd0, 5'd0,  1'b0, 5'd4};
        vecs[5]  = '{3'd3, 5'd2,  1'b1, 5'd2};
        vecs[6]  = '{3'd0, 5'd1,  1'b1, 5'd1};
        vecs[7]  = '{3'd4, 5'd31, 1'b1, 5'd31};
        vecs[8]  = '{3'd5, 5'd0,  1'b1, 5'd0};
        vecs[9]  = '{3'd3, 5'd0,  1'b0, 5'd2};
        vecs[10] = '{3'd7, 5'd3,  1'b0, 5'd0};
        vecs[11] = '{3'd0, 5'd9,  1'b1, 5'd9};

        rst = 1'b1; pgm_in = 1'b0; clr_in = 1'b0;
        param_sel = '0; pgm_value = '0;
        set_defaults();
        repeat (3) @(negedge clk);
        check_all_regs("reset");
        check("reset_wr_ack", wr_ack, 1'b0);
        check("reset_wr_err", wr_err, 1'b0);
        check("reset_dco_load", dco_load, 1'b0);
        check("reset_rd_data", rd_data, 5'd0);
        rst = 1'b0;

        foreach (vecs[k]) do_write(vecs[k], $sformatf("vec%0d", k));

        // Clear rises together with a fresh pgm rise: clear must win.
        @(negedge clk);
        param_sel = 3'd0; pgm_value = 5'd5;
        @(negedge clk);
        clr_in = 1'b1; pgm_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_defaults();
        check_all_regs("clr");
        repeat (3) @(negedge clk);
        clr_in = 1'b0; pgm_in = 1'b0;
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (dco_load === 1'b1) dseen++;
        end
        check("clr_dco_load_pulses", dseen, 32'd1);
        check_all_regs("post_clr");

        v = '{3'd1, 5'd7, 1'b1, 5'd7};
        do_write(v, "recover_ki");

`ifdef ADPLL_CFG_READBACK_EN
        @(negedge clk); param_sel = 3'd1;
        @(posedge clk); #1;
        check("rb_ki", rd_data, 5'd7);
        @(negedge clk); param_sel = 3'd2;
        @(posedge clk); #1;
        check("rb_dco_init", rd_data, 5'd16);
        @(negedge clk); param_sel = 3'd7;
        @(posedge clk); #1;
        check("rb_reserved", rd_data, 5'd0);
`else
        for (int s = 0; s < 8; s++) begin
            @(negedge clk); param_sel = 3'(s);
            @(posedge clk); #1;
            check($sformatf("rb_off_sel%0d", s), rd_data, 5'd0);
        end
`endif

        v = '{3'd0, 5'd12, 1'b1, 5'd12};
        do_write(v, "kp12");

        // Asynchronous reset asserted mid-cycle must act without a clock edge.
        @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        set_defaults();
        check_all_regs("async_rst");
        check("async_rst_wr_ack", wr_ack, 1'b0);
        check("async_rst_rd_data", rd_data, 5'd0);
        check("sb_empty", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
